// File: rtl/env_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : env_mult_if
//  Description : Handshake/data bundle between an envelope stage (master)
//                and the env_mult serial multiplier (slave).
//                  start_i   - single-cycle multiply request
//                  wave_i    - signed waveform sample (WAVE_W)
//                  env_i     - unsigned envelope level (ENV_W)
//                  mix_clr_i - synchronous clear of the mix accumulator
//                  ready_o   - one-cycle "result valid" pulse
//                  busy_o    - multiplier occupied (MULT or DONE)
//                  product_o - signed scaled product (WAVE_W)
//                  mix_o     - signed accumulated mix (WAVE_W+2)
//  Revision    : 1.0 - initial release
// ============================================================================
interface env_mult_if #(
    parameter int WAVE_W = 12,
    parameter int ENV_W  = 8
);
    logic                     start_i;
    logic signed [WAVE_W-1:0] wave_i;
    logic        [ENV_W-1:0]  env_i;
    logic                     mix_clr_i;
    logic                     ready_o;
    logic                     busy_o;
    logic signed [WAVE_W-1:0] product_o;
    logic signed [WAVE_W+1:0] mix_o;

    modport master (
        output start_i, wave_i, env_i, mix_clr_i,
        input  ready_o, busy_o, product_o, mix_o
    );

    modport slave (
        input  start_i, wave_i, env_i, mix_clr_i,
        output ready_o, busy_o, product_o, mix_o
    );
endinterface
`default_nettype wire

// File: rtl/env_mult.sv
`default_nettype none
// ============================================================================
//  Module      : env_mult
//  Description : Serial shift-add multiplier scaling a signed waveform sample
//                by an unsigned envelope level. One envelope bit is consumed
//                per cycle (LSB first); the result is the exact product
//                arithmetically shifted right by ENV_W (floor rounding).
//                Optional mix accumulator compiled in by the macro
//                ENV_MULT_MIX_ACC_EN; without it mix_o is tied to zero.
//  Ports       : clk_i  - clock, rising edge
//                rst_ni - asynchronous active-low reset
//                bus    - env_mult_if.slave (start/operands in,
//                         ready/busy/product/mix out)
//  Revision    : 1.0 - initial release
// ============================================================================
module env_mult #(
    parameter int WAVE_W = 12,
    parameter int ENV_W  = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    env_mult_if.slave  bus
);

    localparam int FULL_W = WAVE_W + ENV_W;
    localparam int CNT_W  = $clog2(ENV_W + 1);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ENV_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic signed [FULL_W-1:0] r_mcand;     // sign-extended wave, shifted left each step
    logic [ENV_W-1:0]         r_mplier;    // envelope, shifted right each step
    logic signed [FULL_W-1:0] r_acc;       // partial sum
    logic [CNT_W-1:0]         r_cnt;
    logic signed [WAVE_W-1:0] r_product;

    logic                     w_accept;
    logic                     w_done_entry;
    logic signed [FULL_W-1:0] w_acc_next;
    logic signed [WAVE_W-1:0] w_prod_next;
    logic                     w_ready;
    logic                     w_busy;

    assign w_accept     = (r_state == S_IDLE) && bus.start_i;
    assign w_done_entry = (r_state == S_MULT) && (r_cnt == C_LAST);
    assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Upper WAVE_W bits of the full product == arithmetic shift right by ENV_W.
    assign w_prod_next  = w_acc_next[FULL_W-1:ENV_W];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. MULT length depends only on the counter,
    // never on operand values.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_i) w_state_next = S_MULT;
            S_MULT:  if (r_cnt == C_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            S_MULT:  w_busy = 1'b1;
            S_DONE: begin
                w_busy  = 1'b1;
                w_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, shift-add, product register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{ENV_W{bus.wave_i[WAVE_W-1]}}, bus.wave_i};
            r_mplier <= bus.env_i;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MULT) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_done_entry) begin
                r_product <= w_prod_next;
            end
        end
    end

    assign bus.ready_o   = w_ready;
    assign bus.busy_o    = w_busy;
    assign bus.product_o = r_product;

`ifdef ENV_MULT_MIX_ACC_EN
    // ------------------------------------------------------------------
    // Mix accumulator: clear takes priority, then the new product is added
    // on the same edge so a coincident clear yields exactly the new product.
    // ------------------------------------------------------------------
    logic signed [WAVE_W+1:0] r_mix;
    logic signed [WAVE_W+1:0] w_prod_ext;

    assign w_prod_ext = {{2{w_prod_next[WAVE_W-1]}}, w_prod_next};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mix <= '0;
        end else if (w_done_entry) begin
            r_mix <= (bus.mix_clr_i ? '0 : r_mix) + w_prod_ext;
        end else if (bus.mix_clr_i) begin
            r_mix <= '0;
        end
    end

    assign bus.mix_o = r_mix;
`else
    logic w_unused;
    assign w_unused  = bus.mix_clr_i;
    assign bus.mix_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_env_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_env_mult
//  Description : Directed self-checking bench for env_mult. Expected values
//                are hand-computed; mix expectations follow whether
//                ENV_MULT_MIX_ACC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_env_mult;

    localparam int WAVE_W = 12;
    localparam int ENV_W  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    env_mult_if #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) bus ();

    env_mult #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: start in cycle 0, operands scrambled every cycle after
    // acceptance, ready expected only in cycle 9, busy in cycles 1..9.
    task automatic run_op(input logic signed [WAVE_W-1:0] w,
                          input logic [ENV_W-1:0] e,
                          input logic signed [WAVE_W-1:0] exp_prod,
                          input int clr_cyc,
                          input string name);
        bus.wave_i  = w;
        bus.env_i   = e;
        bus.start_i = 1'b1;
        bus.mix_clr_i = (clr_cyc == 0);
        tick();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            bus.wave_i    = WAVE_W'($urandom());
            bus.env_i     = ENV_W'($urandom());
            bus.mix_clr_i = (c == clr_cyc);
            checks++;
            if (bus.ready_o !== (c == 9)) begin
                failures++;
                $display("FAIL %s ready cycle %0d: got %b want %b", name, c, bus.ready_o, (c == 9));
            end
            checks++;
            if (bus.busy_o !== (c <= 9)) begin
                failures++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, bus.busy_o, (c <= 9));
            end
            tick();
        end
        bus.mix_clr_i = 1'b0;
        checks++;
        if (bus.product_o !== exp_prod) begin
            failures++;
            $display("FAIL %s product: got %0d want %0d", name, bus.product_o, exp_prod);
        end
    endtask

    task automatic check_mix(input logic signed [WAVE_W+1:0] exp_mix, input string name);
        checks++;
        if (bus.mix_o !== exp_mix) begin
            failures++;
            $display("FAIL %s mix: got %0d want %0d", name, bus.mix_o, exp_mix);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.wave_i    = '0;
        bus.env_i     = '0;
        bus.mix_clr_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.ready_o, bus.busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset ready/busy: got %b want 00", {bus.ready_o, bus.busy_o});
        end
        checks++;
        if (bus.product_o !== 12'sd0) begin
            failures++;
            $display("FAIL reset product: got %0d want 0", bus.product_o);
        end
        check_mix(14'sd0, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        run_op(12'sd2047,  8'd255, 12'sd2039,  -1, "max_pos");
        run_op(-12'sd2048, 8'd255, -12'sd2040, -1, "max_neg");
        run_op(-12'sd1,    8'd1,   -12'sd1,    -1, "floor_m1");
        run_op(12'sd1234,  8'd0,   12'sd0,     -1, "env_zero");
        run_op(12'sd100,   8'd128, 12'sd50,    -1, "half");
        run_op(-12'sd300,  8'd77,  -12'sd91,   -1, "neg_floor");
    endtask

    // start held 20 cycles: accepted in cycles 0 and 10 only.
    task automatic test_back_to_back();
        int n_pulse;
        int first_c;
        int second_c;
        n_pulse  = 0;
        first_c  = -1;
        second_c = -1;
        bus.wave_i = 12'sd100;
        bus.env_i  = 8'd128;
        for (int c = 0; c <= 23; c++) begin
            bus.start_i = (c < 20);
            if (bus.ready_o === 1'b1) begin
                n_pulse++;
                if (n_pulse == 1) first_c = c;
                if (n_pulse == 2) second_c = c;
                checks++;
                if (bus.product_o !== 12'sd50) begin
                    failures++;
                    $display("FAIL b2b product cycle %0d: got %0d want 50", c, bus.product_o);
                end
            end
            tick();
        end
        bus.start_i = 1'b0;
        checks++;
        if (n_pulse != 2 || first_c != 9 || second_c != 19) begin
            failures++;
            $display("FAIL b2b pulses: got n=%0d at %0d,%0d want n=2 at 9,19", n_pulse, first_c, second_c);
        end
    endtask

    task automatic test_reset_mid_mult();
        bus.wave_i  = 12'sd2047;
        bus.env_i   = 8'd255;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready_o, bus.busy_o} !== 2'b00 || bus.product_o !== 12'sd0) begin
            failures++;
            $display("FAIL rst_mid outputs: got ready=%b busy=%b prod=%0d want 0/0/0",
                     bus.ready_o, bus.busy_o, bus.product_o);
        end
        check_mix(14'sd0, "rst_mid");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (bus.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid stray ready cycle %0d: got %b want 0", c, bus.ready_o);
            end
            tick();
        end
        run_op(12'sd2047, 8'd255, 12'sd2039, -1, "after_rst");
    endtask

    task automatic test_mix();
        bus.mix_clr_i = 1'b1;
        tick();
        bus.mix_clr_i = 1'b0;
        check_mix(14'sd0, "mix_clr");
        run_op(12'sd2047,  8'd255, 12'sd2039,  -1, "mix1");
        run_op(12'sd2047,  8'd255, 12'sd2039,  -1, "mix2");
        run_op(-12'sd2048, 8'd255, -12'sd2040, -1, "mix3");
`ifdef ENV_MULT_MIX_ACC_EN
        check_mix(14'sd2038, "mix_sum");
`else
        check_mix(14'sd0, "mix_sum");
`endif
        run_op(12'sd2047,  8'd255, 12'sd2039,  -1, "mix4");
        run_op(-12'sd2048, 8'd255, -12'sd2040, 8,  "mix_clr_done");
`ifdef ENV_MULT_MIX_ACC_EN
        check_mix(-14'sd2040, "mix_clr_done");
`else
        check_mix(14'sd0, "mix_clr_done");
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_mult();
        test_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/env_mult.md
ENV_MULT -- requirements
Module: env_mult

Interface
REQ-001 Parameter WAVE_W, default 12, signed waveform sample width.
REQ-002 Parameter ENV_W, default 8, unsigned envelope width and multiply iteration count.
REQ-003 Reset is asynchronous and active-low; the block has one clock.
REQ-004 clk_i  input  1  clock, all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  single-cycle request to multiply; honoured only in IDLE.
REQ-007 wave_i  input  WAVE_W  signed two's-complement sample.
REQ-008 env_i  input  ENV_W  unsigned envelope level, from the envelope stage's raw output.
REQ-009 ready_o  output  1  one-cycle pulse: result valid; connects to the envelope stage's mult_ready_i.
REQ-010 busy_o  output  1  high in MULT and DONE.
REQ-011 product_o  output  WAVE_W  signed scaled product, held between operations.
REQ-012 mix_clr_i  input  1  synchronous clear of the mix accumulator.
REQ-013 mix_o  output  WAVE_W+2  signed accumulated mix of products.

Function
REQ-014 The FSM SHALL have states IDLE, MULT, DONE: IDLE->MULT on start_i; MULT->DONE after ENV_W MULT cycles; DONE->IDLE unconditionally.
REQ-015 On acceptance, wave_i and env_i SHALL be latched; input changes afterwards SHALL not affect the result.
REQ-016 MULT SHALL be serial shift-add: one envelope bit per cycle, LSB first; the sign-extended wave is added to a (WAVE_W+ENV_W)-bit partial sum when the bit is 1.
REQ-017 The full product SHALL be exact: signed(wave) x unsigned(env), WAVE_W+ENV_W bits, no overflow possible.
REQ-018 product_o SHALL equal full product bits [WAVE_W+ENV_W-1:ENV_W] (arithmetic shift right by ENV_W, floor rounding).
REQ-019 product_o SHALL update on the DONE-entry edge; ready_o SHALL be high for exactly the DONE cycle.
REQ-020 Latency: start_i sampled high in cycle 0 -> ready_o high in cycle ENV_W+1 (cycle 9 at defaults).
REQ-021 start_i while busy_o is high SHALL be ignored and not queued.
REQ-022 start_i high in the DONE cycle SHALL be ignored; start_i in the following IDLE cycle SHALL be accepted (back-to-back throughput ENV_W+2 cycles).
REQ-023 env_i = 0 SHALL yield product_o = 0; the MULT length SHALL NOT depend on operand values.

Reset
REQ-024 Reset SHALL force IDLE, ready_o = 0, busy_o = 0, product_o = 0, mix_o = 0, and clear the partial sum and latched operands.
REQ-025 Reset asserted mid-MULT SHALL abort the operation with no ready_o pulse; after release the block SHALL accept start_i on the first IDLE cycle.

Configuration
REQ-026 Macro ENV_MULT_MIX_ACC_EN SHALL compile in the mix accumulator.
REQ-027 With the macro defined, mix_o SHALL add sign-extended product_o on each DONE-entry edge, with two's-complement wrap on overflow.
REQ-028 With the macro defined, mix_clr_i SHALL zero mix_o on the next edge; if mix_clr_i coincides with the DONE-entry edge, mix_o SHALL equal the new product_o (clear then add).
REQ-029 Without the macro, mix_o SHALL be constant 0, mix_clr_i SHALL be ignored, and no accumulator flops SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 wave=2047, env=255, start in cycle 0 -> ready_o high only in cycle 9, product_o=2039.
REQ-031 wave=-2048, env=255 -> product_o=-2040; wave=-1, env=1 -> product_o=-1 (floor); wave=1234, env=0 -> product_o=0.
REQ-032 start_i held high for 20 cycles with wave=100, env=128 -> exactly two ready_o pulses (cycles 9 and 19), both with product_o=50; operand changes during MULT have no effect.
REQ-033 rst_ni asserted in cycle 4 of MULT -> all outputs 0 immediately, no ready_o pulse; a new start after release completes in 9 cycles.
REQ-034 With ENV_MULT_MIX_ACC_EN: mix_clr_i, then products 2039, 2039, -2040 -> mix_o = 2038; mix_clr_i on the third DONE-entry edge -> mix_o = -2040.
REQ-035 Without ENV_MULT_MIX_ACC_EN: same stimulus as REQ-034 -> mix_o stays 0; product_o and ready_o timing match REQ-030.
